// File: rtl/seq_step_ctrl.sv
// seq_step_ctrl: step scheduler for the sequence player.
// Owns the base-tick prescaler, the IDLE/RUN/PAUSE control FSM, the rate
// selection and the direction logic, and emits the sequence index `pos`.
// Optional build macro: SEQ_PINGPONG_EN (bounce at the ends instead of wrapping,
// with direction latched from `up` on IDLE->RUN and on reset).
module seq_step_ctrl #(
    parameter int fpga_f   = 50_000_000,
    parameter int TICK_CYC = fpga_f / 2,
    parameter int DEPTH    = 8,
    parameter int PW       = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic          stop,
    input  logic          run_tog,
    input  logic          step,
    input  logic          timeS,
    input  logic          up,
    output logic [PW-1:0] pos,
    output logic          step_stb,
    output logic          running,
    output logic          dir,
    output logic          tick_500ms
);

    localparam int CW = (TICK_CYC > 2) ? $clog2(TICK_CYC) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(TICK_CYC - 1);
    localparam logic [PW-1:0] POS_LAST = PW'(DEPTH - 1);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_PAUSE = 2'd2;

    logic [1:0]    state_q, state_d;
    logic [PW-1:0] pos_q, pos_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          phase_q, phase_d;
    logic          stb_q, stb_d;
    logic          tick_q, tick_d;

    logic          tick;
    logic          adv;
    logic [PW-1:0] pos_adv;

`ifdef SEQ_PINGPONG_EN
    localparam logic [PW-1:0] POS_PEN = PW'(DEPTH - 2);
    logic dir_q, dir_d;
    logic dir_adv;

    // Next position/direction for one advance, bouncing at both end points
    always_comb begin
        pos_adv = pos_q;
        dir_adv = dir_q;
        if (dir_q) begin
            if (pos_q == POS_LAST) begin
                pos_adv = POS_PEN;
                dir_adv = 1'b0;
            end else begin
                pos_adv = pos_q + 1'b1;
            end
        end else begin
            if (pos_q == '0) begin
                pos_adv = PW'(1);
                dir_adv = 1'b1;
            end else begin
                pos_adv = pos_q - 1'b1;
            end
        end
    end

    assign dir = dir_q;
`else
    // Next position for one advance, wrapping around in the live direction
    always_comb begin
        pos_adv = pos_q;
        if (up) begin
            pos_adv = (pos_q == POS_LAST) ? '0 : pos_q + 1'b1;
        end else begin
            pos_adv = (pos_q == '0) ? POS_LAST : pos_q - 1'b1;
        end
    end

    assign dir = up;
`endif

    assign tick = (cnt_q == CNT_LAST);

    // Control FSM, prescaler and position update; stop beats run_tog/start beats step beats tick
    always_comb begin
        state_d = state_q;
        pos_d   = pos_q;
        phase_d = phase_q;
        stb_d   = 1'b0;
        tick_d  = tick;
        cnt_d   = tick ? '0 : cnt_q + 1'b1;
        adv     = 1'b0;
`ifdef SEQ_PINGPONG_EN
        dir_d   = dir_q;
`endif
        if (stop) begin
            state_d = ST_IDLE;
            pos_d   = '0;
            phase_d = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        state_d = ST_RUN;
                        phase_d = 1'b0;
                        cnt_d   = '0;
`ifdef SEQ_PINGPONG_EN
                        dir_d   = up;
`endif
                    end
                end
                ST_RUN: begin
                    if (run_tog) begin
                        state_d = ST_PAUSE;
                    end else if (tick) begin
                        phase_d = ~phase_q;
                        adv     = timeS | ~phase_q;
                    end
                end
                ST_PAUSE: begin
                    if (run_tog) begin
                        state_d = ST_RUN;
                        phase_d = 1'b0;
                        cnt_d   = '0;
                    end else if (step) begin
                        adv = 1'b1;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    pos_d   = '0;
                    phase_d = 1'b0;
                end
            endcase
        end
        if (adv) begin
            pos_d = pos_adv;
            stb_d = 1'b1;
`ifdef SEQ_PINGPONG_EN
            dir_d = dir_adv;
`endif
        end
    end

    // State registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            pos_q   <= '0;
            cnt_q   <= '0;
            phase_q <= 1'b0;
            stb_q   <= 1'b0;
            tick_q  <= 1'b0;
`ifdef SEQ_PINGPONG_EN
            dir_q   <= up;
`endif
        end else begin
            state_q <= state_d;
            pos_q   <= pos_d;
            cnt_q   <= cnt_d;
            phase_q <= phase_d;
            stb_q   <= stb_d;
            tick_q  <= tick_d;
`ifdef SEQ_PINGPONG_EN
            dir_q   <= dir_d;
`endif
        end
    end

    assign pos        = pos_q;
    assign step_stb   = stb_q;
    assign running    = (state_q == ST_RUN);
    assign tick_500ms = tick_q;

endmodule
